// File: rtl/spike_rate_decoder.sv
// Spike-train to number converter: counts rising edges per programmable window and measures
// the interval between the last two spikes, delivering results through a one-deep valid/ready buffer.
module spike_rate_decoder #(
   parameter int WIN_W = 16,
   parameter int CNT_W = 8,
   parameter int ISI_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             spike,
   input  logic             enable,
   input  logic [WIN_W-1:0] window_len,
   output logic [CNT_W-1:0] rate,
   output logic [ISI_W-1:0] isi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sat,
   output logic             dropped
);

   typedef enum logic {IDLE, COUNT} state_t;

   localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ISI_W-1:0] ISI_ONE = {{(ISI_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};

   state_t             state_q, state_d;
   logic               spike_d_q, spike_d_d;
   logic [WIN_W-1:0]   len_q, len_d;
   logic [WIN_W-1:0]   wcyc_q, wcyc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ISI_W-1:0]   isi_run_q, isi_run_d;
   logic [ISI_W-1:0]   last_isi_q, last_isi_d;
   logic               have_edge_q, have_edge_d;
   logic               sat_w_q, sat_w_d;
   logic [CNT_W-1:0]   rate_q, rate_d;
   logic [ISI_W-1:0]   isi_q, isi_d;
   logic               sat_q, sat_d;
   logic               out_valid_q, out_valid_d;
   logic               dropped_q, dropped_d;

   logic               spk_edge;
   logic               accept;
   logic [WIN_W-1:0]   start_len;
   logic [CNT_W-1:0]   cnt_n;
   logic [ISI_W-1:0]   isi_run_n;
   logic [ISI_W-1:0]   last_isi_n;
   logic               have_edge_n;
   logic               sat_n;

   assign spk_edge  = spike & ~spike_d_q;
   assign accept    = out_valid_q & out_ready;
   assign start_len = (window_len == '0) ? WIN_ONE : window_len;

   // Per-cycle window update, shared by the final cycle so its edge is part of the result.
   always_comb begin
      cnt_n       = cnt_q;
      isi_run_n   = isi_run_q;
      last_isi_n  = last_isi_q;
      have_edge_n = have_edge_q;
      sat_n       = sat_w_q;
      if (spk_edge) begin
         if (cnt_q != CNT_MAX) cnt_n = cnt_q + CNT_ONE;
         if (cnt_n == CNT_MAX) sat_n = 1'b1;
         if (have_edge_q) last_isi_n = isi_run_q;
         isi_run_n   = ISI_ONE;
         have_edge_n = 1'b1;
      end else if (have_edge_q) begin
         if (isi_run_q != ISI_MAX) isi_run_n = isi_run_q + ISI_ONE;
         if (isi_run_n == ISI_MAX) sat_n = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      spike_d_d   = spike;
      len_d       = len_q;
      wcyc_d      = wcyc_q;
      cnt_d       = cnt_q;
      isi_run_d   = isi_run_q;
      last_isi_d  = last_isi_q;
      have_edge_d = have_edge_q;
      sat_w_d     = sat_w_q;
      rate_d      = rate_q;
      isi_d       = isi_q;
      sat_d       = sat_q;
      out_valid_d = accept ? 1'b0 : out_valid_q;
      dropped_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable) begin
               len_d       = start_len;
               wcyc_d      = '0;
               cnt_d       = '0;
               isi_run_d   = '0;
               last_isi_d  = '0;
               have_edge_d = 1'b0;
               sat_w_d     = 1'b0;
               state_d     = COUNT;
            end
         end
         COUNT: begin
            if (wcyc_q == len_q - WIN_ONE) begin
               // A full buffer that is not being drained this cycle loses the new result.
               if (!out_valid_q || accept) begin
                  rate_d      = cnt_n;
                  isi_d       = last_isi_n;
                  sat_d       = sat_n;
                  out_valid_d = 1'b1;
               end else begin
                  dropped_d = 1'b1;
               end
               if (enable) begin
                  len_d       = start_len;
                  wcyc_d      = '0;
                  cnt_d       = '0;
                  isi_run_d   = '0;
                  last_isi_d  = '0;
                  have_edge_d = 1'b0;
                  sat_w_d     = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               wcyc_d      = wcyc_q + WIN_ONE;
               cnt_d       = cnt_n;
               isi_run_d   = isi_run_n;
               last_isi_d  = last_isi_n;
               have_edge_d = have_edge_n;
               sat_w_d     = sat_n;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         spike_d_q   <= 1'b0;
         len_q       <= '0;
         wcyc_q      <= '0;
         cnt_q       <= '0;
         isi_run_q   <= '0;
         last_isi_q  <= '0;
         have_edge_q <= 1'b0;
         sat_w_q     <= 1'b0;
         rate_q      <= '0;
         isi_q       <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         dropped_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         spike_d_q   <= spike_d_d;
         len_q       <= len_d;
         wcyc_q      <= wcyc_d;
         cnt_q       <= cnt_d;
         isi_run_q   <= isi_run_d;
         last_isi_q  <= last_isi_d;
         have_edge_q <= have_edge_d;
         sat_w_q     <= sat_w_d;
         rate_q      <= rate_d;
         isi_q       <= isi_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         dropped_q   <= dropped_d;
      end
   end

   assign rate      = rate_q;
   assign isi       = isi_q;
   assign sat       = sat_q;
   assign out_valid = out_valid_q;
   assign dropped   = dropped_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: windowed spike counts, ISI, handshake, drops, async reset.
module tb_spike_rate_decoder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        spike;
   logic        enable;
   logic [15:0] window_len;
   logic [7:0]  rate;
   logic [15:0] isi;
   logic        out_valid;
   logic        out_ready;
   logic        sat;
   logic        dropped;

   int checks   = 0;
   int failures = 0;

   spike_rate_decoder #(.WIN_W(16), .CNT_W(8), .ISI_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .spike      (spike),
      .enable     (enable),
      .window_len (window_len),
      .rate       (rate),
      .isi        (isi),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sat        (sat),
      .dropped    (dropped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic result(input string tag, input int v, input int r, input int i, input int s);
      chk({tag, "_valid"}, 32'(out_valid), 32'(v));
      chk({tag, "_rate"},  32'(rate),      32'(r));
      chk({tag, "_isi"},   32'(isi),       32'(i));
      chk({tag, "_sat"},   32'(sat),       32'(s));
      $display("txn %s: valid=%0d rate=%0d isi=%0d sat=%0d dropped=%0d", tag, out_valid, rate, isi, sat, dropped);
   endtask

   // Drives one whole window; the last cycle presents the length for the following window.
   task automatic win(input int n, input logic [63:0] pat, input logic [15:0] next_len);
      for (int i = 0; i < n; i++) begin
         spike = pat[i];
         if (i == n - 1) window_len = next_len;
         step();
      end
   endtask

   initial begin
      reset_n = 1'b0; spike = 1'b0; enable = 1'b0; window_len = '0; out_ready = 1'b0;
      #12;
      result("reset", 0, 0, 0, 0);
      chk("reset_dropped", 32'(dropped), 32'd0);
      reset_n = 1'b1;
      step();

      // 1: spikes at 2,5,9 of a 10-cycle window
      enable = 1'b1; window_len = 16'd10; out_ready = 1'b1;
      step();
      win(10, 64'h224, 16'd8);
      result("t1", 1, 3, 4, 0);

      // 2: held spike, single spike, no spike
      win(8, 64'h7E, 16'd8);
      result("t2_held", 1, 1, 0, 0);
      win(8, 64'h08, 16'd8);
      result("t2_single", 1, 1, 0, 0);
      win(8, 64'h00, 16'd4);
      result("t2_none", 1, 0, 0, 0);

      // 3: stalled consumer, second window dropped
      spike = 1'b1; step();
      chk("t3_accept_clears", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      spike = 1'b0; step();
      spike = 1'b0; step();
      spike = 1'b1; step();
      result("t3_w1", 1, 2, 3, 0);
      win(4, 64'hA, 16'd4);
      result("t3_w2_held", 1, 2, 3, 0);
      chk("t3_dropped", 32'(dropped), 32'd1);
      spike = 1'b0; step();
      chk("t3_dropped_pulse", 32'(dropped), 32'd0);
      chk("t3_still_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1; step();
      chk("t3_released", 32'(out_valid), 32'd0);
      win(2, 64'h0, 16'd600);
      result("t3_w3", 1, 0, 0, 0);

      // 4: 300 edges saturate the 8-bit count
      for (int i = 0; i < 600; i++) begin
         spike = (i % 2 == 0);
         if (i == 599) window_len = 16'd0;
         step();
      end
      result("t4", 1, 255, 2, 1);

      // 5: zero length gives back-to-back one-cycle windows
      spike = 1'b0; step();
      result("t5_a", 1, 0, 0, 0);
      spike = 1'b1; step();
      result("t5_edge", 1, 1, 0, 0);
      spike = 1'b1; step();
      result("t5_held", 1, 0, 0, 0);
      spike = 1'b0; step();
      spike = 1'b1; step();
      result("t5_edge2", 1, 1, 0, 0);
      enable = 1'b0; spike = 1'b0; step();
      result("t5_last", 1, 0, 0, 0);
      step();
      chk("t5_idle_valid", 32'(out_valid), 32'd0);
      spike = 1'b1; step();
      spike = 1'b0; step();
      chk("t5_idle_quiet", 32'(out_valid), 32'd0);

      // 6: async reset mid-window with a result pending
      enable = 1'b1; window_len = 16'd3; out_ready = 1'b0;
      step();
      win(3, 64'h2, 16'd10);
      result("t6_pre", 1, 1, 0, 0);
      spike = 1'b1; step();
      spike = 1'b0; step();
      #2;
      reset_n = 1'b0;
      #1;
      result("t6_async", 0, 0, 0, 0);
      chk("t6_async_dropped", 32'(dropped), 32'd0);
      #3;
      reset_n = 1'b1;
      out_ready = 1'b1; window_len = 16'd10;
      step();
      win(10, 64'h10, 16'd10);
      result("t6_post", 1, 1, 0, 0);
      enable = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
